// File: rtl/ad9363_iq_framer.sv
`default_nettype none
// ============================================================================
//  Module      : ad9363_iq_framer
//  Description : Pin-side framer/deframer for the AD9363 12-bit LVCMOS data
//                ports. TX side buffers whole frames in a FIFO and emits a
//                continuous word stream with TX_FRAME marking. RX side checks
//                the RX_FRAME pattern, reassembles frames and resyncs on error.
//  Revision    : 1.0 - initial release
// ============================================================================
module ad9363_iq_framer #(
   parameter int SAMPLE_W    = 12,
   parameter int NUM_CH      = 1,
   parameter int FIFO_DEPTH  = 8,
   parameter int IDLE_REPEAT = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         tx_en,
   input  logic                         tx_valid,
   input  logic [NUM_CH*2*SAMPLE_W-1:0] tx_data,
   output logic                         tx_ready,
   output logic                         tx_frame,
   output logic [11:0]                  p1_d,
   input  logic                         rx_frame,
   input  logic [11:0]                  p0_d,
   output logic                         rx_valid,
   output logic [NUM_CH*2*SAMPLE_W-1:0] rx_data,
   output logic                         tx_underflow,
   output logic                         rx_sync_err,
   output logic [15:0]                  tx_underflow_cnt,
   output logic [15:0]                  rx_sync_err_cnt
);

   localparam int C_W  = SAMPLE_W;
   localparam int C_S  = 2 * NUM_CH;             // words per frame
   localparam int C_FW = C_S * C_W;              // frame width in bits
   localparam int C_AW = $clog2(FIFO_DEPTH);

   localparam logic [1:0]    C_LAST    = 2'(C_S - 1);
   localparam logic [1:0]    C_NCH     = 2'(NUM_CH);
   localparam logic [C_AW:0] C_PTR_ONE = 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   // Word j of a frame sits at [j*W +: W]; placed MSB-aligned on the 12-bit bus.
   function automatic logic [11:0] f_word(input logic [C_FW-1:0] frame, input logic [1:0] slot);
      logic [11:0] word;
      word            = '0;
      word[11 -: C_W] = frame[slot*C_W +: C_W];
      return word;
   endfunction

   // Frame marker is high for the first half of the frame (the I/Q of channel 0..NUM_CH-1 "I half").
   function automatic logic f_marker(input logic [1:0] slot);
      return (slot < C_NCH);
   endfunction

   // ------------------------------------------------------------------------
   // TX frame FIFO
   // ------------------------------------------------------------------------
   logic [C_FW-1:0] r_mem [FIFO_DEPTH];
   logic [C_AW:0]   r_wptr;
   logic [C_AW:0]   r_rptr;
   logic            r_ready_en;
   logic            w_full;
   logic            w_empty;
   logic            w_push;
   logic            w_pop;
   logic [C_FW-1:0] w_head;
   logic [C_FW-1:0] w_fill;

   logic [0:0]      r_state;
   logic [1:0]      r_slot;
   logic [C_FW-1:0] r_cur;

   assign w_empty  = (r_wptr == r_rptr);
   assign w_full   = (r_wptr[C_AW] != r_rptr[C_AW]) &&
                     (r_wptr[C_AW-1:0] == r_rptr[C_AW-1:0]);
   assign tx_ready = r_ready_en & ~w_full;
   assign w_push   = tx_valid & tx_ready;
   assign w_head   = r_mem[r_rptr[C_AW-1:0]];
   assign w_fill   = (IDLE_REPEAT != 0) ? r_cur : '0;

   // A frame is popped only at a frame boundary (from IDLE or at the last slot).
   assign w_pop    = tx_en & ~w_empty & ((r_state == S_IDLE) | (r_slot == C_LAST));

   // Keeps tx_ready low while in reset and for the release edge itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_ready_en <= 1'b0;
      else        r_ready_en <= 1'b1;
   end

   // FIFO storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[C_AW-1:0]] <= tx_data;
   end

   // FIFO read/write pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + C_PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + C_PTR_ONE;
      end
   end

   // TX framer: slot sequencing, pin registers and underflow fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_slot           <= '0;
         r_cur            <= '0;
         tx_frame         <= 1'b0;
         p1_d             <= '0;
         tx_underflow     <= 1'b0;
         tx_underflow_cnt <= '0;
      end else begin
         tx_underflow <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (tx_en && !w_empty) begin
                  r_cur    <= w_head;
                  p1_d     <= f_word(w_head, 2'd0);
                  tx_frame <= 1'b1;
                  r_slot   <= '0;
                  r_state  <= S_RUN;
               end else begin
                  p1_d     <= '0;
                  tx_frame <= 1'b0;
               end
            end
            default: begin
               if (r_slot != C_LAST) begin
                  r_slot   <= r_slot + 2'd1;
                  p1_d     <= f_word(r_cur, r_slot + 2'd1);
                  tx_frame <= f_marker(r_slot + 2'd1);
               end else if (!tx_en) begin
                  // Frame just completed; stop cleanly at the boundary.
                  r_state  <= S_IDLE;
                  r_slot   <= '0;
                  p1_d     <= '0;
                  tx_frame <= 1'b0;
               end else if (!w_empty) begin
                  r_cur    <= w_head;
                  p1_d     <= f_word(w_head, 2'd0);
                  tx_frame <= 1'b1;
                  r_slot   <= '0;
               end else begin
                  // Starved: keep the frame timing alive with a fill frame.
                  r_cur        <= w_fill;
                  p1_d         <= f_word(w_fill, 2'd0);
                  tx_frame     <= 1'b1;
                  r_slot       <= '0;
                  tx_underflow <= 1'b1;
                  if (tx_underflow_cnt != 16'hFFFF)
                     tx_underflow_cnt <= tx_underflow_cnt + 16'd1;
               end
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // RX deframer
   // ------------------------------------------------------------------------
   logic            r_rx_prev;
   logic            r_rx_sync;
   logic [1:0]      r_rx_slot;
   logic [C_FW-1:0] r_rx_buf;
   logic            w_rise;
   logic            w_rx_match;
   logic [1:0]      w_cap_slot;
   logic [C_W-1:0]  w_rx_field;
   logic [C_FW-1:0] w_rx_merged;

   assign w_rise     = rx_frame & ~r_rx_prev;
   assign w_rx_match = r_rx_sync & (rx_frame == f_marker(r_rx_slot));
   assign w_rx_field = p0_d[11 -: C_W];
   // A word that breaks sync but is itself a rising edge becomes slot 0.
   assign w_cap_slot = w_rx_match ? r_rx_slot : 2'd0;

   // Assembly buffer with the current word dropped into its slot.
   always_comb begin
      w_rx_merged                         = r_rx_buf;
      w_rx_merged[w_cap_slot*C_W +: C_W]  = w_rx_field;
   end

   // RX alignment tracking, frame assembly and error accounting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_prev       <= 1'b0;
         r_rx_sync       <= 1'b0;
         r_rx_slot       <= '0;
         r_rx_buf        <= '0;
         rx_valid        <= 1'b0;
         rx_data         <= '0;
         rx_sync_err     <= 1'b0;
         rx_sync_err_cnt <= '0;
      end else begin
         r_rx_prev   <= rx_frame;
         rx_valid    <= 1'b0;
         rx_sync_err <= 1'b0;
         if (w_rx_match) begin
            r_rx_buf <= w_rx_merged;
            if (r_rx_slot == C_LAST) begin
               rx_data   <= w_rx_merged;
               rx_valid  <= 1'b1;
               r_rx_slot <= '0;
            end else begin
               r_rx_slot <= r_rx_slot + 2'd1;
            end
         end else begin
            if (r_rx_sync) begin
               rx_sync_err <= 1'b1;
               if (rx_sync_err_cnt != 16'hFFFF)
                  rx_sync_err_cnt <= rx_sync_err_cnt + 16'd1;
            end
            if (w_rise) begin
               r_rx_sync <= 1'b1;
               r_rx_buf  <= w_rx_merged;
               r_rx_slot <= 2'd1;
            end else begin
               r_rx_sync <= 1'b0;
               r_rx_slot <= '0;
            end
         end
      end
   end

endmodule
`default_nettype wire
